// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings, transmitter FSM state type and clocks-per-bit rounding helper
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_RSVD = 2'b11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: 0..DIV-1 bit-period counter (clk, reset, clear in; one-cycle bit_tick out at DIV-1)
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    bit_tick = cnt_q == CW'(DIV - 1);
    cnt_d = (clear || bit_tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter (clk, reset, tx_valid/tx_data/parity_mode/stop2 in; tx_ready, txd, busy, done out)
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_param
    $error("uart_tx_param: DIV must be >= 2 and DATA_BITS within 5..9");
  end
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic par_q, par_d, par_en_q, par_en_d, stop2_q, stop2_d, txd_q, txd_d;
  logic bit_tick, accept, last_data, last_stop;
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk(clk),
    .reset(reset),
    .clear(state_q == IDLE),
    .bit_tick(bit_tick)
  );
  always_comb begin
    tx_ready = !reset && state_q == IDLE;
    accept = tx_valid && tx_ready;
    last_data = bit_cnt_q == 4'(DATA_BITS - 1);
    last_stop = bit_cnt_q == {3'b000, stop2_q};
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d = par_q;
    par_en_d = par_en_q;
    stop2_d = stop2_q;
    if (accept) begin
      state_d = START;
      shift_d = tx_data;
      bit_cnt_d = '0;
      par_d = ^tx_data ^ (parity_mode == PAR_ODD);
      par_en_d = parity_mode != PAR_NONE && parity_mode != PAR_RSVD;
      stop2_d = stop2;
    end else if (bit_tick) begin
      unique case (state_q)
        START: begin
          state_d = DATA;
          bit_cnt_d = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          bit_cnt_d = last_data ? '0 : bit_cnt_q + 1'b1;
          state_d = !last_data ? DATA : par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          state_d = STOP;
          bit_cnt_d = '0;
        end
        STOP: begin
          bit_cnt_d = last_stop ? '0 : bit_cnt_q + 1'b1;
          state_d = last_stop ? IDLE : STOP;
        end
        default: ;
      endcase
    end
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
    txd = txd_q;
    busy = state_q != IDLE;
    done = !reset && state_q == STOP && bit_tick && last_stop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_cnt_q <= '0;
      par_q <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q <= par_d;
      par_en_q <= par_en_d;
      stop2_q <= stop2_d;
      txd_q <= txd_d;
    end
  end
endmodule
